// File: rtl/key_tone_sequencer.sv
// Matrix keypad scanner with frame-level debouncing, a small key-event FIFO
// and a tone player that turns each queued key into a fixed-length square-wave burst.
module key_tone_sequencer #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int KEY_W      = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_CNT    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int NW         = 12,
    parameter int BASE       = 750,
    parameter int STEP       = 50,
    parameter int TONE_LEN   = 25000000,
    parameter int GAP_LEN    = 2500000
) (
    input  logic             clk,
    input  logic             rst,
    output logic [COLS-1:0]  col,
    input  logic [ROWS-1:0]  fila,
    output logic             key_valid,
    output logic [KEY_W-1:0] key_code,
    output logic             tone,
    output logic             busy,
    output logic             ovf
);

    localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W    = $clog2(DEB_CNT + 1);
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LEN_MAX  = (TONE_LEN > GAP_LEN) ? TONE_LEN : GAP_LEN;
    localparam int LEN_W    = $clog2(LEN_MAX + 1);
    localparam int HW       = KEY_W + 34;
    localparam int HALF_MAX = (1 << NW) - 1;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    logic [SCAN_W-1:0] scan_cnt;
    logic [COL_W-1:0]  col_idx;
    logic              dwell_end;
    logic              frame_end;

    logic [1:0]        col_hits;
    logic [KEY_W-1:0]  col_code;
    logic [1:0]        acc_hits;
    logic [KEY_W-1:0]  acc_code;
    logic [2:0]        hit_sum;
    logic [1:0]        merged_hits;
    logic [KEY_W-1:0]  merged_code;
    logic              frame_valid;

    logic              cand_valid;
    logic [KEY_W-1:0]  cand_code;
    logic [DEB_W-1:0]  deb_cnt;
    logic [DEB_W-1:0]  deb_next;
    logic              same;
    logic              accept_now;
    logic              stable_valid;
    logic [KEY_W-1:0]  stable_code;
    logic              press_evt;

    logic [KEY_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              full;
    logic              empty;
    logic              pop;
    logic              push_ok;
    logic [KEY_W-1:0]  head;

    state_t            state, state_d;
    logic [KEY_W-1:0]  cur_code, cur_code_d;
    logic [NW-1:0]     half, half_d;
    logic [NW-1:0]     half_cnt, half_cnt_d;
    logic [LEN_W-1:0]  len_cnt, len_cnt_d;
    logic              tone_d;
    logic [HW-1:0]     half_wide;
    logic [NW-1:0]     half_sat;

    assign dwell_end = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign frame_end = dwell_end && (col_idx == COL_W'(COLS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            col_idx  <= '0;
        end else if (dwell_end) begin
            scan_cnt <= '0;
            col_idx  <= (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + COL_W'(1);
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    always_comb begin
        col          = '0;
        col[col_idx] = 1'b1;
    end

    // Hit count saturates at 2: anything beyond "more than one" is a reject anyway.
    always_comb begin
        col_hits = 2'd0;
        col_code = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (fila[r]) begin
                if (col_hits != 2'd2) begin
                    col_hits = col_hits + 2'd1;
                end
                col_code = KEY_W'(r * COLS) + KEY_W'(col_idx);
            end
        end
    end

    always_comb begin
        hit_sum     = {1'b0, acc_hits} + {1'b0, col_hits};
        merged_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        merged_code = (col_hits != 2'd0) ? col_code : acc_code;
        frame_valid = (merged_hits == 2'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_hits <= 2'd0;
            acc_code <= '0;
        end else if (frame_end) begin
            acc_hits <= 2'd0;
            acc_code <= '0;
        end else if (dwell_end) begin
            acc_hits <= merged_hits;
            acc_code <= merged_code;
        end
    end

    // A frame result becomes stable once it has repeated DEB_CNT frames in a row.
    always_comb begin
        same = (frame_valid == cand_valid) && (!frame_valid || (merged_code == cand_code));
        if (same) begin
            deb_next = (deb_cnt == DEB_W'(DEB_CNT)) ? deb_cnt : deb_cnt + DEB_W'(1);
        end else begin
            deb_next = DEB_W'(1);
        end
        accept_now = (deb_next >= DEB_W'(DEB_CNT));
        press_evt  = frame_end && accept_now && frame_valid &&
                     !(stable_valid && (stable_code == merged_code));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_valid   <= 1'b0;
            cand_code    <= '0;
            deb_cnt      <= '0;
            stable_valid <= 1'b0;
            stable_code  <= '0;
        end else if (frame_end) begin
            cand_valid <= frame_valid;
            cand_code  <= merged_code;
            deb_cnt    <= deb_next;
            if (accept_now) begin
                stable_valid <= frame_valid;
                stable_code  <= merged_code;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            key_valid <= press_evt;
            if (press_evt) begin
                key_code <= merged_code;
            end
        end
    end

    assign full    = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = press_evt && (!full || pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= merged_code;
        end
    end

    // A push into a full FIFO survives only if the player drains a slot in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            if (press_evt && !push_ok) begin
                ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        half_wide = HW'(BASE) + HW'(STEP) * HW'(cur_code);
        if (half_wide > HW'(HALF_MAX)) begin
            half_sat = NW'(HALF_MAX);
        end else if (half_wide == '0) begin
            half_sat = NW'(1);
        end else begin
            half_sat = half_wide[NW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur_code <= '0;
            half     <= '0;
            half_cnt <= '0;
            len_cnt  <= '0;
            tone     <= 1'b0;
        end else begin
            state    <= state_d;
            cur_code <= cur_code_d;
            half     <= half_d;
            half_cnt <= half_cnt_d;
            len_cnt  <= len_cnt_d;
            tone     <= tone_d;
        end
    end

    // len_cnt is shared by PLAY and GAP since only one of them runs at a time.
    always_comb begin
        state_d    = state;
        cur_code_d = cur_code;
        half_d     = half;
        half_cnt_d = half_cnt;
        len_cnt_d  = len_cnt;
        tone_d     = tone;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                tone_d = 1'b0;
                if (!empty) begin
                    pop        = 1'b1;
                    cur_code_d = head;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                half_d     = half_sat;
                half_cnt_d = '0;
                len_cnt_d  = '0;
                tone_d     = 1'b0;
                state_d    = PLAY;
            end
            PLAY: begin
                if (len_cnt == LEN_W'(TONE_LEN - 1)) begin
                    len_cnt_d = '0;
                    tone_d    = 1'b0;
                    state_d   = GAP;
                end else begin
                    len_cnt_d = len_cnt + LEN_W'(1);
                    if (half_cnt == half - NW'(1)) begin
                        half_cnt_d = '0;
                        tone_d     = ~tone;
                    end else begin
                        half_cnt_d = half_cnt + NW'(1);
                    end
                end
            end
            GAP: begin
                tone_d = 1'b0;
                if (len_cnt == LEN_W'(GAP_LEN - 1)) begin
                    len_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    len_cnt_d = len_cnt + LEN_W'(1);
                end
            end
            default: begin
                tone_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
